tick_monitor: RTL and testbench

TICK_MONITOR -- requirements
Module: tick_monitor

---
 rtl/tick_mon_pkg.sv | 27 ++
 rtl/tick_monitor_if.sv | 41 ++++
 rtl/tick_window_cmp.sv | 26 ++
 rtl/tick_monitor.sv | 166 ++++++++++++++++
 tb/tb_tick_monitor.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_mon_pkg.sv
// Shared types and default constants for the tick_monitor block.
// Optional period statistics are enabled with the TICK_MONITOR_STATS_EN macro.
package tick_mon_pkg;

  localparam int DEF_EXPECTED   = 50000;
  localparam int DEF_TOLERANCE  = 2;
  localparam int DEF_LOCK_COUNT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_e;

  // Where the running interval stands relative to the acceptance window.
  typedef enum logic [1:0] {
    CLS_EARLY     = 2'd0,
    CLS_IN_WINDOW = 2'd1,
    CLS_LATE      = 2'd2
  } win_cls_e;

  // Counter width able to hold the timeout value EXPECTED+TOLERANCE+1.
  function automatic int cnt_bits(input int expected, input int tolerance);
    return $clog2(expected + tolerance + 2);
  endfunction

endpackage

// File: rtl/tick_monitor_if.sv
// Control and status bundle between a tick source/consumer and tick_monitor.
// Statistics signals exist only when TICK_MONITOR_STATS_EN is defined.
interface tick_monitor_if #(
  parameter int BITS = tick_mon_pkg::cnt_bits(tick_mon_pkg::DEF_EXPECTED,
                                              tick_mon_pkg::DEF_TOLERANCE)
);

  logic            en;
  logic            tick;
  logic            clr_err;
  logic [BITS-1:0] period;
  logic            period_valid;
  logic            err_early;
  logic            err_late;
  logic            lock;
`ifdef TICK_MONITOR_STATS_EN
  logic [BITS-1:0] period_min;
  logic [BITS-1:0] period_max;

  modport master (
    output en, tick, clr_err,
    input  period, period_valid, err_early, err_late, lock, period_min, period_max
  );

  modport slave (
    input  en, tick, clr_err,
    output period, period_valid, err_early, err_late, lock, period_min, period_max
  );
`else
  modport master (
    output en, tick, clr_err,
    input  period, period_valid, err_early, err_late, lock
  );

  modport slave (
    input  en, tick, clr_err,
    output period, period_valid, err_early, err_late, lock
  );
`endif

endinterface

// File: rtl/tick_window_cmp.sv
// Combinational classifier of the running interval count against the
// early bound (EXPECTED-TOLERANCE) and the timeout (EXPECTED+TOLERANCE+1).
module tick_window_cmp
  import tick_mon_pkg::*;
#(
  parameter int EXPECTED  = DEF_EXPECTED,
  parameter int TOLERANCE = DEF_TOLERANCE,
  parameter int BITS      = cnt_bits(DEF_EXPECTED, DEF_TOLERANCE)
) (
  input  logic [BITS-1:0] cnt,
  output win_cls_e        cls
);

  localparam logic [BITS-1:0] LO_BOUND = BITS'(EXPECTED - TOLERANCE);
  localparam logic [BITS-1:0] TIMEOUT  = BITS'(EXPECTED + TOLERANCE + 1);

  always_comb begin
    cls = CLS_IN_WINDOW;
    if (cnt >= TIMEOUT) begin
      cls = CLS_LATE;
    end else if (cnt < LO_BOUND) begin
      cls = CLS_EARLY;
    end
  end

endmodule

// File: rtl/tick_monitor.sv
// Measures tick-to-tick intervals, flags early/late ticks and reports lock.
// Define TICK_MONITOR_STATS_EN to add period_min/period_max tracking.
module tick_monitor
  import tick_mon_pkg::*;
#(
  parameter int EXPECTED   = DEF_EXPECTED,
  parameter int TOLERANCE  = DEF_TOLERANCE,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic         clk,
  input  logic         rst,
  tick_monitor_if.slave bus
);

  localparam int BITS = $clog2(EXPECTED + TOLERANCE + 2);
  localparam int GW   = $clog2(LOCK_COUNT + 1);

  localparam logic [GW-1:0]   GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [BITS-1:0] CNT_ONE  = BITS'(1);

  if (TOLERANCE >= EXPECTED) begin : g_bad_tolerance
    $error("tick_monitor: TOLERANCE must be smaller than EXPECTED");
  end

  state_e          state_q, state_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] period_q, period_d;
  logic            pv_q, pv_d;
  logic            early_q, early_d;
  logic            late_q, late_d;
  logic            lock_q, lock_d;
  logic [GW-1:0]   good_q, good_d;
  logic [GW-1:0]   good_inc;
  win_cls_e        cls;

  tick_window_cmp #(
    .EXPECTED (EXPECTED),
    .TOLERANCE(TOLERANCE),
    .BITS     (BITS)
  ) u_window (
    .cnt(cnt_q),
    .cls(cls)
  );

  always_comb begin
    // NOTE: every _d takes a default first, so no branch can leave a latch behind.
    state_d  = state_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    lock_d   = lock_q;
    period_d = period_q;
    pv_d     = 1'b0;
    // A new error later in this block overrides the clear.
    early_d  = bus.clr_err ? 1'b0 : early_q;
    late_d   = bus.clr_err ? 1'b0 : late_q;
    good_inc = (good_q == GOOD_MAX) ? good_q : good_q + GW'(1);

    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      good_d  = '0;
      lock_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
          cnt_d   = '0;
        end
        ARMED: begin
          if (bus.tick) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
          end
        end
        MEASURE: begin
          // Timeout wins over a tick arriving on the same cycle.
          if (cls == CLS_LATE) begin
            late_d  = 1'b1;
            good_d  = '0;
            lock_d  = 1'b0;
            cnt_d   = '0;
            state_d = ARMED;
          end else if (bus.tick) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            cnt_d    = CNT_ONE;
            if (cls == CLS_EARLY) begin
              early_d = 1'b1;
              good_d  = '0;
              lock_d  = 1'b0;
            end else begin
              good_d = good_inc;
              lock_d = (good_inc >= GOOD_MAX);
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values.
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      early_q  <= early_d;
      late_q   <= late_d;
      lock_q   <= lock_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.err_early    = early_q;
  assign bus.err_late     = late_q;
  assign bus.lock         = lock_q;

`ifdef TICK_MONITOR_STATS_EN
  logic [BITS-1:0] min_q, min_d, min_base;
  logic [BITS-1:0] max_q, max_d, max_base;

  // Stats restart from clr_err, then fold in any period produced this cycle.
  always_comb begin
    min_base = bus.clr_err ? '1 : min_q;
    max_base = bus.clr_err ? '0 : max_q;
    min_d    = min_base;
    max_d    = max_base;
    if (pv_d) begin
      if (period_d < min_base) min_d = period_d;
      if (period_d > max_base) max_d = period_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign bus.period_min = min_q;
  assign bus.period_max = max_q;
`endif

endmodule

// File: tb/tb_tick_monitor.sv
// Self-checking bench for tick_monitor (EXPECTED=10, TOLERANCE=1, LOCK_COUNT=3)
// against a tick-timestamp reference model; honours TICK_MONITOR_STATS_EN.
module tb_tick_monitor;
  import tick_mon_pkg::*;

  localparam int E    = 10;
  localparam int T    = 1;
  localparam int LC   = 3;
  localparam int BITS = $clog2(E + T + 2);
`ifdef TICK_MONITOR_STATS_EN
  localparam int OW = 3 * BITS + 4;
`else
  localparam int OW = BITS + 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  tick_monitor_if #(.BITS(BITS)) bus ();

  tick_monitor #(
    .EXPECTED  (E),
    .TOLERANCE (T),
    .LOCK_COUNT(LC)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: remembers when the reference tick happened and works
  // out intervals as differences of cycle numbers.
  int              cyc;
  int              m_t0;
  int              m_good;
  bit              m_active;
  bit              m_meas;
  bit              m_lock, m_pv, m_early, m_late;
  logic [BITS-1:0] m_period, m_min, m_max;

  task automatic model_reset();
    m_active = 0; m_meas = 0; m_good = 0; m_lock = 0;
    m_pv = 0; m_early = 0; m_late = 0; m_period = '0;
    m_min = '1; m_max = '0;
  endtask

  task automatic model_step(input bit en, input bit tick, input bit clr);
    int el;
    m_pv = 0;
    if (clr) begin
      m_early = 0; m_late = 0; m_min = '1; m_max = '0;
    end
    if (!en) begin
      m_active = 0; m_meas = 0; m_good = 0; m_lock = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else if (!m_meas) begin
      if (tick) begin
        m_meas = 1; m_t0 = cyc;
      end
    end else begin
      el = cyc - m_t0;
      if (el >= E + T + 1) begin
        m_late = 1; m_good = 0; m_lock = 0; m_meas = 0;
      end else if (tick) begin
        m_pv = 1; m_period = BITS'(el); m_t0 = cyc;
        if (m_period < m_min) m_min = m_period;
        if (m_period > m_max) m_max = m_period;
        if (el < E - T) begin
          m_early = 1; m_good = 0; m_lock = 0;
        end else begin
          if (m_good < LC) m_good++;
          m_lock = (m_good >= LC);
        end
      end
    end
    cyc++;
  endtask

  function automatic logic [OW-1:0] dut_vec();
    return {bus.period, bus.period_valid, bus.err_early, bus.err_late, bus.lock
`ifdef TICK_MONITOR_STATS_EN
            , bus.period_min, bus.period_max
`endif
           };
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    return {m_period, m_pv, m_early, m_late, m_lock
`ifdef TICK_MONITOR_STATS_EN
            , m_min, m_max
`endif
           };
  endfunction

  // One clock of stimulus; the model advances and the whole output bundle is compared.
  task automatic step(input bit en, input bit tick, input bit clr, input string name);
    bus.en = en; bus.tick = tick; bus.clr_err = clr;
    @(posedge clk);
    model_step(en, tick, clr);
    #1;
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_miss++;
      $display("FAIL %s: cycle %0d outputs %h, model wants %h", name, cyc, dut_vec(), exp_vec());
    end
  endtask

  task automatic interval(input int gap, input bit clr_on_tick, input string name);
    repeat (gap - 1) step(1'b1, 1'b0, 1'b0, name);
    step(1'b1, 1'b1, clr_on_tick, name);
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.en = 1'b0; bus.tick = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.period, bus.period_valid, bus.err_early, bus.err_late, bus.lock} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: got %h, want 0",
               {bus.period, bus.period_valid, bus.err_early, bus.err_late, bus.lock});
    end
    n_vec++;
    if (u_dut.state_q !== IDLE) begin
      n_miss++;
      $display("FAIL reset_state: got %0d, want IDLE", u_dut.state_q);
    end
`ifdef TICK_MONITOR_STATS_EN
    n_vec++;
    if ({bus.period_min, bus.period_max} !== {{BITS{1'b1}}, {BITS{1'b0}}}) begin
      n_miss++;
      $display("FAIL reset_stats: got %h/%h, want all-ones/0", bus.period_min, bus.period_max);
    end
`endif
    model_reset();
    cyc = 0;
    rst = 1'b1;
  endtask

  task automatic test_steady();
    step(1'b1, 1'b0, 1'b0, "steady_arm");
    step(1'b1, 1'b1, 1'b0, "steady_first_tick");
    for (int k = 1; k <= 3; k++) begin
      interval(10, 1'b0, "steady");
      n_vec++;
      if ({bus.period_valid, bus.period, bus.lock, bus.err_early, bus.err_late} !==
          {1'b1, BITS'(10), (k >= 3), 2'b00}) begin
        n_miss++;
        $display("FAIL steady_interval%0d: pv/period/lock/early/late %b/%0d/%b/%b/%b, want 1/10/%0d/0/0",
                 k, bus.period_valid, bus.period, bus.lock, bus.err_early, bus.err_late, k >= 3);
      end
    end
    step(1'b1, 1'b0, 1'b0, "steady_pulse_end");
  endtask

  task automatic test_early();
    step(1'b0, 1'b0, 1'b0, "early_idle");
    step(1'b1, 1'b0, 1'b0, "early_arm");
    step(1'b1, 1'b1, 1'b0, "early_first_tick");
    repeat (3) interval(10, 1'b0, "early_lockup");
    interval(8, 1'b0, "early_short");
    n_vec++;
    if ({bus.period_valid, bus.period, bus.err_early, bus.lock} !== {1'b1, BITS'(8), 1'b1, 1'b0}) begin
      n_miss++;
      $display("FAIL early_detect: pv/period/early/lock %b/%0d/%b/%b, want 1/8/1/0",
               bus.period_valid, bus.period, bus.err_early, bus.lock);
    end
    step(1'b1, 1'b0, 1'b1, "early_clear");
  endtask

  task automatic test_late();
    step(1'b0, 1'b0, 1'b0, "late_idle");
    step(1'b1, 1'b0, 1'b0, "late_arm");
    step(1'b1, 1'b1, 1'b0, "late_first_tick");
    repeat (11) step(1'b1, 1'b0, 1'b0, "late_wait");
    n_vec++;
    if (bus.err_late !== 1'b0) begin
      n_miss++;
      $display("FAIL late_too_soon: err_late %b at counter 11, want 0", bus.err_late);
    end
    step(1'b1, 1'b0, 1'b0, "late_timeout");
    n_vec++;
    if ({bus.err_late, bus.period_valid, u_dut.state_q} !== {1'b1, 1'b0, ARMED}) begin
      n_miss++;
      $display("FAIL late_timeout: late/pv/state %b/%b/%0d, want 1/0/ARMED",
               bus.err_late, bus.period_valid, u_dut.state_q);
    end
    step(1'b1, 1'b1, 1'b0, "late_rearm_tick");
  endtask

  task automatic test_boundary();
    step(1'b0, 1'b0, 1'b1, "bound_idle_clr");
    step(1'b1, 1'b0, 1'b0, "bound_arm");
    step(1'b1, 1'b1, 1'b0, "bound_first_tick");
    interval(9, 1'b0, "bound_9");
    n_vec++;
    if ({bus.period_valid, bus.period, bus.err_early, bus.err_late} !== {1'b1, BITS'(9), 2'b00}) begin
      n_miss++;
      $display("FAIL bound_9: pv/period/early/late %b/%0d/%b/%b, want 1/9/0/0",
               bus.period_valid, bus.period, bus.err_early, bus.err_late);
    end
    interval(11, 1'b0, "bound_11");
    n_vec++;
    if ({bus.period_valid, bus.period, bus.err_early, bus.err_late} !== {1'b1, BITS'(11), 2'b00}) begin
      n_miss++;
      $display("FAIL bound_11: pv/period/early/late %b/%0d/%b/%b, want 1/11/0/0",
               bus.period_valid, bus.period, bus.err_early, bus.err_late);
    end
    interval(12, 1'b0, "bound_12");
    n_vec++;
    if ({bus.period_valid, bus.err_early, bus.err_late} !== 3'b001) begin
      n_miss++;
      $display("FAIL bound_12: pv/early/late %b/%b/%b, want 0/0/1",
               bus.period_valid, bus.err_early, bus.err_late);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b0, "rmid_tick");
    repeat (5) step(1'b1, 1'b0, 1'b0, "rmid_partial");
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bus.period, bus.period_valid, bus.err_early, bus.err_late, bus.lock} !== '0) begin
      n_miss++;
      $display("FAIL rmid_async: got %h, want 0",
               {bus.period, bus.period_valid, bus.err_early, bus.err_late, bus.lock});
    end
    model_reset();
    #1;
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, "rmid_arm");
    step(1'b1, 1'b1, 1'b0, "rmid_first_tick");
    n_vec++;
    if (bus.period_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL rmid_first_tick: period_valid %b, want 0", bus.period_valid);
    end
    interval(10, 1'b0, "rmid_second");
    n_vec++;
    if ({bus.period_valid, bus.period} !== {1'b1, BITS'(10)}) begin
      n_miss++;
      $display("FAIL rmid_second_tick: pv/period %b/%0d, want 1/10", bus.period_valid, bus.period);
    end
  endtask

  task automatic test_clr_err();
    step(1'b0, 1'b0, 1'b0, "clr_idle");
    step(1'b1, 1'b0, 1'b0, "clr_arm");
    step(1'b1, 1'b1, 1'b0, "clr_first_tick");
    repeat (12) step(1'b1, 1'b0, 1'b0, "clr_wait");
    step(1'b1, 1'b0, 1'b1, "clr_late");
    n_vec++;
    if (bus.err_late !== 1'b0) begin
      n_miss++;
      $display("FAIL clr_late: err_late %b after clr_err, want 0", bus.err_late);
    end
    step(1'b1, 1'b1, 1'b0, "clr_rearm");
    repeat (4) step(1'b1, 1'b0, 1'b0, "clr_short");
    step(1'b1, 1'b1, 1'b1, "clr_with_early");
    n_vec++;
    if ({bus.err_early, bus.err_late, bus.period} !== {2'b10, BITS'(5)}) begin
      n_miss++;
      $display("FAIL clr_vs_early: early/late/period %b/%b/%0d, want 1/0/5",
               bus.err_early, bus.err_late, bus.period);
    end
  endtask

  task automatic test_random();
    step(1'b0, 1'b0, 1'b1, "rand_idle");
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(6, 14);
      if ($urandom_range(0, 19) == 0) step(1'b0, 1'b0, 1'b0, "rand_en_drop");
      for (int i = 1; i < gap; i++) step(1'b1, 1'b0, $urandom_range(0, 15) == 0, "rand_gap");
      step(1'b1, 1'b1, $urandom_range(0, 15) == 0, "rand_tick");
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_early();
    test_late();
    test_boundary();
    test_reset_mid();
    test_clr_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
